// File: rtl/ds_frame_ctrl_if.sv
// Frame-controller bus: start/configuration, pixel handshake, mapper drive and status.
// master = frame source / mapper side, slave = ds_frame_ctrl.
interface ds_frame_ctrl_if #(
    parameter int AWIDTH = 11,
    parameter int EXTEND = 30
);
    logic                       start;
    logic [AWIDTH-1:0]          cfg_width;
    logic [AWIDTH-1:0]          cfg_height;
    logic [AWIDTH-1:0]          cfg_out_width;
    logic [AWIDTH-1:0]          cfg_out_height;
    logic                       s_valid;
    logic                       s_ready;
    logic                       vacancy;
    logic [AWIDTH-1:0]          width;
    logic [AWIDTH-1:0]          height;
    logic [AWIDTH+EXTEND-1:0]   resolution_width;
    logic [AWIDTH+EXTEND-1:0]   resolution_height;
    logic [AWIDTH-1:0]          cnt_col;
    logic [AWIDTH-1:0]          cnt_row;
    logic                       map_valid;
    logic                       map_clken;
    logic [2*AWIDTH-1:0]        kept_count;
    logic                       busy;
    logic                       done;
    logic                       cfg_err;

    modport master (
        output start, cfg_width, cfg_height, cfg_out_width, cfg_out_height,
        output s_valid, vacancy,
        input  s_ready, width, height, resolution_width, resolution_height,
        input  cnt_col, cnt_row, map_valid, map_clken, kept_count, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_width, cfg_height, cfg_out_width, cfg_out_height,
        input  s_valid, vacancy,
        output s_ready, width, height, resolution_width, resolution_height,
        output cnt_col, cnt_row, map_valid, map_clken, kept_count, busy, done, cfg_err
    );
endinterface

// File: rtl/ds_frame_ctrl.sv
// Frame sequencer for the SGM downsample path: validates geometry, divides out the
// fixed-point resolution steps, then walks one raster frame and counts kept pixels.
//
// state  | meaning
// IDLE   | waiting for start; cfg latched and checked on start
// CALC   | restoring division, one quotient bit per cycle, AWIDTH+EXTEND cycles
// RUN    | pixel handshake open, raster counters advance on each fire
// DONE   | one-cycle end-of-frame pulse
module ds_frame_ctrl #(
    parameter int AWIDTH = 11,
    parameter int EXTEND = 30
) (
    input  logic             clk,
    input  logic             rst,
    ds_frame_ctrl_if.slave   bus
);
    localparam int QW = AWIDTH + EXTEND;
    localparam int KW = 2 * AWIDTH;
    localparam int CW = $clog2(QW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] width_q, width_d, height_q, height_d;
    logic [AWIDTH-1:0] owidth_q, owidth_d, oheight_q, oheight_d;
    logic [QW-1:0]     dvd_w_q, dvd_w_d, dvd_h_q, dvd_h_d;
    logic [AWIDTH-1:0] rem_w_q, rem_w_d, rem_h_q, rem_h_d;
    logic [QW-1:0]     quo_w_q, quo_w_d, quo_h_q, quo_h_d;
    logic [QW-1:0]     res_w_q, res_w_d, res_h_q, res_h_d;
    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic [AWIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [KW-1:0]     kept_q, kept_d;
    logic              cfg_err_q, cfg_err_d;

    logic              fire;
    logic              cfg_bad;
    logic [AWIDTH:0]   part_w, part_h;
    logic              qbit_w, qbit_h;
    logic [AWIDTH-1:0] rem_w_nx, rem_h_nx;
    logic [QW-1:0]     quo_w_nx, quo_h_nx;

    assign fire = bus.s_valid && (state_q == S_RUN);

    assign cfg_bad = (bus.cfg_width == '0) || (bus.cfg_height == '0) ||
                     (bus.cfg_out_width == '0) || (bus.cfg_out_height == '0) ||
                     (bus.cfg_out_width > bus.cfg_width) ||
                     (bus.cfg_out_height > bus.cfg_height);

    // The partial remainder stays below the divisor, so an AWIDTH-bit subtract is exact.
    assign part_w   = {rem_w_q, dvd_w_q[QW-1]};
    assign part_h   = {rem_h_q, dvd_h_q[QW-1]};
    assign qbit_w   = (part_w >= {1'b0, owidth_q});
    assign qbit_h   = (part_h >= {1'b0, oheight_q});
    assign rem_w_nx = qbit_w ? (part_w[AWIDTH-1:0] - owidth_q)  : part_w[AWIDTH-1:0];
    assign rem_h_nx = qbit_h ? (part_h[AWIDTH-1:0] - oheight_q) : part_h[AWIDTH-1:0];
    assign quo_w_nx = {quo_w_q[QW-2:0], qbit_w};
    assign quo_h_nx = {quo_h_q[QW-2:0], qbit_h};

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        owidth_d  = owidth_q;
        oheight_d = oheight_q;
        dvd_w_d   = dvd_w_q;
        dvd_h_d   = dvd_h_q;
        rem_w_d   = rem_w_q;
        rem_h_d   = rem_h_q;
        quo_w_d   = quo_w_q;
        quo_h_d   = quo_h_q;
        res_w_d   = res_w_q;
        res_h_d   = res_h_q;
        div_cnt_d = div_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        kept_d    = kept_q;
        cfg_err_d = cfg_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    width_d   = bus.cfg_width;
                    height_d  = bus.cfg_height;
                    owidth_d  = bus.cfg_out_width;
                    oheight_d = bus.cfg_out_height;
                    kept_d    = '0;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = S_CALC;
                        dvd_w_d   = {bus.cfg_width,  {EXTEND{1'b0}}};
                        dvd_h_d   = {bus.cfg_height, {EXTEND{1'b0}}};
                        rem_w_d   = '0;
                        rem_h_d   = '0;
                        quo_w_d   = '0;
                        quo_h_d   = '0;
                        div_cnt_d = CW'(QW - 1);
                    end
                end
            end
            S_CALC: begin
                dvd_w_d = {dvd_w_q[QW-2:0], 1'b0};
                dvd_h_d = {dvd_h_q[QW-2:0], 1'b0};
                rem_w_d = rem_w_nx;
                rem_h_d = rem_h_nx;
                quo_w_d = quo_w_nx;
                quo_h_d = quo_h_nx;
                // Published steps only change on the final quotient bit.
                if (div_cnt_q == '0) begin
                    res_w_d = quo_w_nx;
                    res_h_d = quo_h_nx;
                    state_d = S_RUN;
                end else begin
                    div_cnt_d = div_cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (bus.vacancy && (kept_q != '1)) begin
                        kept_d = kept_q + KW'(1);
                    end
                    if (col_q == width_q - AWIDTH'(1)) begin
                        col_d = '0;
                        if (row_q == height_q - AWIDTH'(1)) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + AWIDTH'(1);
                        end
                    end else begin
                        col_d = col_q + AWIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            owidth_q  <= '0;
            oheight_q <= '0;
            dvd_w_q   <= '0;
            dvd_h_q   <= '0;
            rem_w_q   <= '0;
            rem_h_q   <= '0;
            quo_w_q   <= '0;
            quo_h_q   <= '0;
            res_w_q   <= '0;
            res_h_q   <= '0;
            div_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            kept_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            owidth_q  <= owidth_d;
            oheight_q <= oheight_d;
            dvd_w_q   <= dvd_w_d;
            dvd_h_q   <= dvd_h_d;
            rem_w_q   <= rem_w_d;
            rem_h_q   <= rem_h_d;
            quo_w_q   <= quo_w_d;
            quo_h_q   <= quo_h_d;
            res_w_q   <= res_w_d;
            res_h_q   <= res_h_d;
            div_cnt_q <= div_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            kept_q    <= kept_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.s_ready           = (state_q == S_RUN);
    assign bus.map_clken         = (state_q == S_RUN);
    assign bus.map_valid         = fire;
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.done              = (state_q == S_DONE);
    assign bus.width             = width_q;
    assign bus.height            = height_q;
    assign bus.resolution_width  = res_w_q;
    assign bus.resolution_height = res_h_q;
    assign bus.cnt_col           = col_q;
    assign bus.cnt_row           = row_q;
    assign bus.kept_count        = kept_q;
    assign bus.cfg_err           = cfg_err_q;
endmodule

// File: tb/tb_ds_frame_ctrl.sv
// Directed bench for ds_frame_ctrl: step values, raster walk, kept count, errors,
// ignored starts, mid-frame reset and the 1x1 corner.
module tb_ds_frame_ctrl;
    localparam int AW = 11;
    localparam int EX = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ds_frame_ctrl_if #(.AWIDTH(AW), .EXTEND(EX)) bus ();
    ds_frame_ctrl #(.AWIDTH(AW), .EXTEND(EX)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [63:0] prev_rw = '0;
    logic [63:0] prev_rh = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic vac_of(input int c, input int r, input logic sel);
        logic base;
        base = (((c + r) % 3) == 0);
        return base ^ sel;
    endfunction

    task automatic drive_cfg(input int w, input int h, input int ow, input int oh);
        bus.cfg_width      = AW'(w);
        bus.cfg_height     = AW'(h);
        bus.cfg_out_width  = AW'(ow);
        bus.cfg_out_height = AW'(oh);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_width"},  bus.width, 0);
        chk({tag, "_height"}, bus.height, 0);
        chk({tag, "_res_w"},  bus.resolution_width, 0);
        chk({tag, "_res_h"},  bus.resolution_height, 0);
        chk({tag, "_col"},    bus.cnt_col, 0);
        chk({tag, "_row"},    bus.cnt_row, 0);
        chk({tag, "_kept"},   bus.kept_count, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_done"},   bus.done, 0);
        chk({tag, "_err"},    bus.cfg_err, 0);
        chk({tag, "_ready"},  bus.s_ready, 0);
        chk({tag, "_clken"},  bus.map_clken, 0);
        chk({tag, "_mvalid"}, bus.map_valid, 0);
    endtask

    task automatic try_err(input int w, input int h, input int ow, input int oh);
        drive_cfg(w, h, ow, oh);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_flag", bus.cfg_err, 1);
        chk("err_busy", bus.busy, 0);
        tick();
        chk("err_busy2", bus.busy, 0);
        chk("err_ready", bus.s_ready, 0);
        chk("err_sticky", bus.cfg_err, 1);
        chk("err_res_w", bus.resolution_width, prev_rw);
    endtask

    task automatic run_frame(input int w, input int h, input int ow, input int oh,
                             input int duty, input logic sel, input bit inject, input int abort_at);
        int calc_n, fires, cyc, col, row, kept;
        logic v, f;
        logic [63:0] exp_rw, exp_rh;
        exp_rw = (64'(w) << EX) / 64'(ow);
        exp_rh = (64'(h) << EX) / 64'(oh);

        drive_cfg(w, h, ow, oh);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_err_clr", bus.cfg_err, 0);
        chk("start_busy", bus.busy, 1);
        chk("calc_ready", bus.s_ready, 0);
        chk("calc_hold_w", bus.resolution_width, prev_rw);
        chk("calc_hold_h", bus.resolution_height, prev_rh);

        calc_n = 0;
        while (!bus.s_ready && calc_n < 100) begin
            if (inject && calc_n == 10) begin
                drive_cfg(16, 16, 2, 2);
                bus.start = 1'b1;
            end
            if (calc_n == 20) chk("calc_mid_w", bus.resolution_width, prev_rw);
            tick();
            bus.start = 1'b0;
            calc_n++;
        end
        chk("calc_len", calc_n, AW + EX);
        chk("res_w", bus.resolution_width, exp_rw);
        chk("res_h", bus.resolution_height, exp_rh);
        chk("lat_width", bus.width, w);
        chk("lat_height", bus.height, h);
        chk("run_clken", bus.map_clken, 1);
        prev_rw = exp_rw;
        prev_rh = exp_rh;

        fires = 0; cyc = 0; col = 0; row = 0; kept = 0;
        while (fires < w * h && cyc < 20 * w * h + 100) begin
            if (fires == abort_at) begin
                rst = 1'b0;
                #1;
                chk_zero("abort_async");
                tick();
                chk_zero("abort_held");
                rst = 1'b1;
                bus.s_valid = 1'b0;
                prev_rw = '0;
                prev_rh = '0;
                return;
            end
            v = vac_of(col, row, sel);
            f = (duty >= 100) || ($urandom_range(99) < duty);
            bus.s_valid = f;
            bus.vacancy = v;
            if (inject && fires == 20 && f) begin
                drive_cfg(8, 4, 8, 4);
                bus.start = 1'b1;
            end
            #1;
            chk("map_valid", bus.map_valid, f);
            if (f) begin
                chk("cnt_col", bus.cnt_col, col);
                chk("cnt_row", bus.cnt_row, row);
            end
            tick();
            bus.start = 1'b0;
            cyc++;
            if (f) begin
                fires++;
                if (v) kept++;
                col++;
                if (col == w) begin
                    col = 0;
                    row++;
                end
            end
        end
        chk("fire_count", fires, w * h);
        if (duty >= 100) chk("run_len", cyc, w * h);
        bus.s_valid = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_ready", bus.s_ready, 0);
        chk("done_clken", bus.map_clken, 0);
        chk("done_col", bus.cnt_col, 0);
        chk("done_row", bus.cnt_row, 0);
        chk("kept", bus.kept_count, kept);
        tick();
        chk("post_done", bus.done, 0);
        chk("post_busy", bus.busy, 0);
        chk("post_kept", bus.kept_count, kept);
        chk("post_width", bus.width, w);
        chk("post_res_w", bus.resolution_width, exp_rw);
        chk("post_res_h", bus.resolution_height, exp_rh);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.vacancy = 1'b0;
        drive_cfg(0, 0, 0, 0);
        #12;
        chk_zero("reset");
        rst = 1'b1;
        tick();
        chk_zero("idle");

        run_frame(8, 8, 4, 4, 100, 1'b0, 1'b0, -1);
        try_err(8, 8, 0, 4);
        try_err(8, 8, 4, 9);
        run_frame(8, 8, 4, 4, 100, 1'b1, 1'b1, -1);
        run_frame(8, 8, 4, 4, 100, 1'b0, 1'b0, 43);
        run_frame(8, 8, 4, 4, 60, 1'b1, 1'b0, -1);
        run_frame(640, 480, 320, 240, 40, 1'b0, 1'b0, 2000);
        run_frame(40, 30, 20, 15, 40, 1'b0, 1'b0, -1);
        run_frame(8, 6, 3, 5, 100, 1'b1, 1'b0, -1);
        run_frame(1, 1, 1, 1, 100, 1'b0, 1'b0, -1);
        run_frame(1, 1, 1, 1, 100, 1'b1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
